// File: rtl/reg_scoreboard_pkg.sv
// Shared core types for the register scoreboard: producer latency classes
// and the architectural register address width.
package reg_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        LAT_ALU    = 2'd0,
        LAT_LOAD   = 2'd1,
        LAT_MULDIV = 2'd2,
        LAT_RSVD   = 2'd3
    } lat_class_e;

    // Countdown width; never below one bit so a zero latency still elaborates.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat == 0) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// One scoreboard entry: a pending flag plus a load-latency countdown.
// MULDIV entries stay pending until the matching writeback clears them.
module sb_entry #(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_set_load,
    input  logic i_set_mdu,
    input  logic i_clr_mdu,
    output logic o_pending
);

    logic             r_pending;
    logic [CNT_W-1:0] r_cnt;

    // Sets win over any clear that lands in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_cnt     <= '0;
        end else if (i_set_load) begin
            r_pending <= (LOAD_LAT != 0);
            r_cnt     <= CNT_W'(LOAD_LAT);
        end else if (i_set_mdu) begin
            r_pending <= 1'b1;
            r_cnt     <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_pending <= 1'b0;
            end
        end else if (i_clr_mdu) begin
            r_pending <= 1'b0;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: tracks long-latency producers (LOAD,
// MULDIV) and stalls dependent or structurally conflicting instructions.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_write,
    input  logic [1:0]            id_lat_class,
    input  logic                  id_valid,
    input  logic                  flush,
    input  logic                  wb_mdu_valid,
    input  logic [REG_ADDR_W-1:0] wb_mdu_rd,
    output logic                  stall,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic                  mdu_busy
);

    localparam int unsigned CNT_W = cnt_width(LOAD_LAT);

    logic [NUM_REGS-1:0]   w_set_load;
    logic [NUM_REGS-1:0]   w_set_mdu;
    logic [NUM_REGS-1:0]   w_clr_mdu;
    logic [NUM_REGS-1:0]   w_pending;
    logic                  w_issue;
    logic                  w_is_load;
    logic                  w_is_mdu;
    logic                  w_mdu_wb;
    logic                  w_hazard;
    logic                  r_mdu_busy;
    logic [REG_ADDR_W-1:0] r_mdu_tag;

    assign w_is_load = id_reg_write && (id_lat_class == LAT_LOAD);
    assign w_is_mdu  = id_reg_write && (id_lat_class == LAT_MULDIV);
    assign w_mdu_wb  = r_mdu_busy && wb_mdu_valid && (wb_mdu_rd == r_mdu_tag);

    // Hazards come from registered state only, so a clear releases a cycle later.
    always_comb begin
        w_hazard = 1'b0;
        if (id_rs1_used && w_pending[id_rs1_addr]) begin
            w_hazard = 1'b1;
        end
        if (id_rs2_used && w_pending[id_rs2_addr]) begin
            w_hazard = 1'b1;
        end
        if (id_reg_write && w_pending[id_rd_addr]) begin
            w_hazard = 1'b1;
        end
        if ((id_lat_class == LAT_MULDIV) && r_mdu_busy) begin
            w_hazard = 1'b1;
        end
    end

    assign stall   = rst_n && id_valid && w_hazard;
    assign w_issue = id_valid && !stall && !flush;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        if (i == 0) begin : g_zero
            assign w_set_load[i] = 1'b0;
            assign w_set_mdu[i]  = 1'b0;
            assign w_clr_mdu[i]  = 1'b0;
        end else begin : g_live
            assign w_set_load[i] = w_issue && w_is_load && (id_rd_addr == REG_ADDR_W'(i));
            assign w_set_mdu[i]  = w_issue && w_is_mdu && (id_rd_addr == REG_ADDR_W'(i));
            assign w_clr_mdu[i]  = w_mdu_wb && (r_mdu_tag == REG_ADDR_W'(i));
        end

        sb_entry #(
            .LOAD_LAT (LOAD_LAT),
            .CNT_W    (CNT_W)
        ) u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_set_load (w_set_load[i]),
            .i_set_mdu  (w_set_mdu[i]),
            .i_clr_mdu  (w_clr_mdu[i]),
            .o_pending  (w_pending[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdu_busy <= 1'b0;
            r_mdu_tag  <= '0;
        end else if (w_issue && w_is_mdu) begin
            r_mdu_busy <= 1'b1;
            r_mdu_tag  <= id_rd_addr;
        end else if (w_mdu_wb) begin
            r_mdu_busy <= 1'b0;
        end
    end

    assign busy_vec = w_pending;
    assign mdu_busy = r_mdu_busy;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_reg_scoreboard;

    localparam int unsigned LOAD_LAT = 1;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd_addr;
    logic        id_reg_write;
    logic [1:0]  id_lat_class;
    logic        id_valid;
    logic        flush;
    logic        wb_mdu_valid;
    logic [4:0]  wb_mdu_rd;
    logic        stall;
    logic [31:0] busy_vec;
    logic        mdu_busy;

    int checks = 0;
    int errors = 0;

    // Model: a load keeps its register pending until an absolute cycle number;
    // a MULDIV keeps it pending until its writeback.
    int unsigned load_until [32];
    bit          mdu_pend   [32];
    bit          m_busy;
    logic [4:0]  m_tag;
    int unsigned now = 0;

    reg_scoreboard #(
        .NUM_REGS (32),
        .LOAD_LAT (LOAD_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd_addr   (id_rd_addr),
        .id_reg_write (id_reg_write),
        .id_lat_class (id_lat_class),
        .id_valid     (id_valid),
        .flush        (flush),
        .wb_mdu_valid (wb_mdu_valid),
        .wb_mdu_rd    (wb_mdu_rd),
        .stall        (stall),
        .busy_vec     (busy_vec),
        .mdu_busy     (mdu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit pend(input int r);
        return (r != 0) && ((load_until[r] > now) || mdu_pend[r]);
    endfunction

    task automatic drive(input logic v, input logic [4:0] a1, input logic u1,
                         input logic [4:0] a2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic [1:0] cls, input logic fl);
        id_valid     = v;
        id_rs1_addr  = a1;
        id_rs1_used  = u1;
        id_rs2_addr  = a2;
        id_rs2_used  = u2;
        id_rd_addr   = rd;
        id_reg_write = we;
        id_lat_class = cls;
        flush        = fl;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd);
        wb_mdu_valid = v;
        wb_mdu_rd    = rd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Per-cycle compare against the model, then advance the model.
    initial begin : compare
        logic [31:0] exp_vec;
        logic        exp_stall;
        logic        iss;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int r = 0; r < 32; r++) begin
                    load_until[r] = 0;
                    mdu_pend[r]   = 1'b0;
                end
                m_busy = 1'b0;
                m_tag  = 5'd0;
                check("rst_stall", 32'(stall), 32'd0);
                check("rst_busy_vec", busy_vec, 32'd0);
                check("rst_mdu_busy", 32'(mdu_busy), 32'd0);
            end else begin
                exp_vec = '0;
                for (int r = 1; r < 32; r++) exp_vec[r] = pend(r);
                exp_stall = id_valid && ((id_rs1_used && exp_vec[id_rs1_addr])
                          || (id_rs2_used && exp_vec[id_rs2_addr])
                          || (id_reg_write && exp_vec[id_rd_addr])
                          || (id_lat_class == 2'd2 && m_busy));
                check("cmp_stall", 32'(stall), 32'(exp_stall));
                check("cmp_busy_vec", busy_vec, exp_vec);
                check("cmp_mdu_busy", 32'(mdu_busy), 32'(m_busy));
                iss = id_valid && !exp_stall && !flush;
                if (wb_mdu_valid && m_busy && wb_mdu_rd == m_tag) begin
                    mdu_pend[m_tag] = 1'b0;
                    m_busy          = 1'b0;
                end
                if (iss && id_reg_write && id_lat_class == 2'd1 && id_rd_addr != 5'd0) begin
                    load_until[id_rd_addr] = now + 1 + LOAD_LAT;
                end
                if (iss && id_reg_write && id_lat_class == 2'd2) begin
                    m_busy = 1'b1;
                    m_tag  = id_rd_addr;
                    if (id_rd_addr != 5'd0) mdu_pend[id_rd_addr] = 1'b1;
                end
            end
            now++;
        end
    end

    initial begin : stim
        rst_n = 1'b0;
        idle();
        wb(1'b0, 5'd0);
        tick();
        tick();
        neg();
        check("reset_busy_vec", busy_vec, 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        tick();
        rst_n = 1'b1;

        // Load-use: LOAD x5 then ADD x6,x5,x1.
        tick(); drive(1, 0, 0, 0, 0, 5, 1, 2'd1, 0);
        neg();  check("lu_load_issue", 32'(stall), 32'd0);
        tick(); drive(1, 5, 1, 1, 1, 6, 1, 2'd0, 0);
        neg();  check("lu_stall", 32'(stall), 32'd1);
                check("lu_busy", busy_vec, 32'h0000_0020);
        tick(); neg();
                check("lu_release", 32'(stall), 32'd0);
                check("lu_cleared", busy_vec, 32'd0);

        // MULDIV dependency: MUL x7 then SUB x8,x7,x2.
        tick(); drive(1, 0, 0, 0, 0, 7, 1, 2'd2, 0);
        neg();  check("mul_issue", 32'(stall), 32'd0);
        tick(); drive(1, 7, 1, 2, 1, 8, 1, 2'd0, 0);
        neg();  check("mul_dep_stall", 32'(stall), 32'd1);
                check("mul_busy", 32'(mdu_busy), 32'd1);
                check("mul_vec", busy_vec, 32'h0000_0080);
        tick(); wb(1, 7);
        neg();  check("mul_wb_cycle_stall", 32'(stall), 32'd1);
        tick(); wb(0, 0);
        neg();  check("mul_release", 32'(stall), 32'd0);
                check("mul_mdu_clear", 32'(mdu_busy), 32'd0);
                check("mul_vec_clear", busy_vec, 32'd0);

        // Structural: DIV x10 outstanding, DIV x9 waits; stray writeback ignored.
        tick(); drive(1, 0, 0, 0, 0, 10, 1, 2'd2, 0);
        neg();
        tick(); drive(1, 0, 0, 0, 0, 9, 1, 2'd2, 0);
        neg();  check("struct_stall", 32'(stall), 32'd1);
        tick(); wb(1, 3);
        neg();
        tick(); wb(0, 0);
        neg();  check("stray_ignored_busy", 32'(mdu_busy), 32'd1);
                check("stray_ignored_vec", busy_vec, 32'h0000_0400);
        tick(); wb(1, 10);
        neg();  check("struct_wb_cycle", 32'(stall), 32'd1);
        tick(); wb(0, 0);
        neg();  check("struct_release", 32'(stall), 32'd0);
        tick(); idle();
        neg();  check("div9_pending", busy_vec, 32'h0000_0200);
        tick(); wb(1, 9);
        neg();
        tick(); wb(0, 0);
        neg();  check("div9_done", 32'(mdu_busy), 32'd0);

        // x0 is never tracked.
        tick(); drive(1, 0, 0, 0, 0, 0, 1, 2'd1, 0);
        neg();
        tick(); drive(1, 0, 1, 0, 1, 1, 1, 2'd0, 0);
        neg();  check("x0_stall", 32'(stall), 32'd0);
                check("x0_busy", busy_vec, 32'd0);

        // WAW with flush: MUL x4 pending, LOAD x4 flushed then retried.
        tick(); drive(1, 0, 0, 0, 0, 4, 1, 2'd2, 0);
        neg();
        tick(); drive(1, 0, 0, 0, 0, 4, 1, 2'd1, 1);
        neg();  check("waw_flush_vec", busy_vec, 32'h0000_0010);
        tick(); drive(1, 0, 0, 0, 0, 4, 1, 2'd1, 0);
        neg();  check("waw_stall", 32'(stall), 32'd1);
        tick(); wb(1, 4);
        neg();  check("waw_wb_cycle", 32'(stall), 32'd1);
        tick(); wb(0, 0);
        neg();  check("waw_release", 32'(stall), 32'd0);
        tick(); idle();
        neg();  check("waw_load_pending", busy_vec, 32'h0000_0010);
        tick(); neg();
                check("waw_load_done", busy_vec, 32'd0);
        tick(); drive(1, 0, 0, 0, 0, 11, 1, 2'd1, 1);
        neg();
        tick(); idle();
        neg();  check("flush_no_entry", busy_vec, 32'd0);

        // Mid-operation reset with MUL x3 outstanding and a dependent waiting.
        tick(); drive(1, 0, 0, 0, 0, 3, 1, 2'd2, 0);
        neg();
        tick(); drive(1, 3, 1, 0, 0, 12, 1, 2'd0, 0);
        neg();  check("pre_rst_stall", 32'(stall), 32'd1);
        tick(); rst_n = 1'b0;
        #1;
        check("midrst_vec", busy_vec, 32'd0);
        check("midrst_mdu", 32'(mdu_busy), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        neg();
        tick(); rst_n = 1'b1; idle();
        neg();  check("post_rst_mdu", 32'(mdu_busy), 32'd0);

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst_n = ($urandom_range(0, 399) != 0);
            drive($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 1'($urandom),
                  5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 7) == 0);
            if (m_busy && $urandom_range(0, 3) == 0) begin
                wb(1, m_tag);
            end else if (m_busy && $urandom_range(0, 7) == 0) begin
                wb(1, m_tag ^ 5'd1);
            end else begin
                wb(0, 5'($urandom_range(0, 31)));
            end
        end

        tick();
        rst_n = 1'b1;
        idle();
        wb(0, 0);
        neg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural integer registers tracked.
REQ-002 SHALL have parameter LOAD_LAT, default 1, number of stall cycles owed to a load-use consumer.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports id_rs1_addr and id_rs2_addr, input, 5 each, decode-stage source register addresses.
REQ-006 SHALL have ports id_rs1_used and id_rs2_used, input, 1 each, asserted when the decode-stage instruction reads that source.
REQ-007 SHALL have port id_rd_addr, input, 5, decode-stage destination address.
REQ-008 SHALL have port id_reg_write, input, 1, asserted when the decode-stage instruction writes rd.
REQ-009 SHALL have port id_lat_class, input, 2, producer class: 0 ALU, 1 LOAD, 2 MULDIV, 3 reserved (treated as ALU).
REQ-010 SHALL have port id_valid, input, 1, asserted when the decode-stage instruction is live.
REQ-011 SHALL have port flush, input, 1, asserted when the decode-stage instruction is killed by a redirect this cycle.
REQ-012 SHALL have ports wb_mdu_valid (input, 1) and wb_mdu_rd (input, 5), MULDIV result writeback strobe and its destination.
REQ-013 SHALL have port stall, output, 1, hold the decode stage this cycle.
REQ-014 SHALL have port busy_vec, output, NUM_REGS, per-register pending flags.
REQ-015 SHALL have port mdu_busy, output, 1, asserted while a MULDIV operation is outstanding.

Function
REQ-016 SHALL define issue as id_valid && !stall && !flush.
REQ-017 SHALL keep, per register, a pending flag plus a countdown of width clog2(LOAD_LAT+1).
REQ-018 SHALL assert stall combinationally when id_valid is high and any of the following holds, all evaluated from registered state only:
- an id_rsN_used source has its pending flag set;
- id_reg_write is high and id_rd_addr is pending (WAW hazard);
- id_lat_class is MULDIV and mdu_busy is high.
REQ-019 SHALL ignore register 0 entirely: its flag is never set and it never causes a stall.
REQ-020 SHALL, on issue of a LOAD with id_reg_write high, set pending[rd] and load the countdown with LOAD_LAT.
REQ-021 SHALL decrement a nonzero LOAD countdown every cycle, and clear pending when it reaches 0.
REQ-022 SHALL, on issue of a MULDIV with id_reg_write high, set pending[rd], set mdu_busy, and record rd as the MDU tag.
REQ-023 SHALL, when wb_mdu_valid is high and wb_mdu_rd equals the MDU tag, clear pending[tag] and mdu_busy on the next edge.
REQ-024 SHALL ignore a wb_mdu_valid whose rd mismatches the tag, and SHALL NOT change state for it.
REQ-025 SHALL create no entry on issue of an ALU-class instruction; the forwarding paths cover those.
REQ-026 SHALL, when a set and a clear target the same register in the same cycle, give priority to the set.
REQ-027 SHALL NOT release stall in the cycle of a clear; the release appears one cycle after the clearing edge.
REQ-028 SHALL make flush suppress issue only; existing entries belong to older instructions and are retained.
REQ-029 SHALL drive stall low whenever id_valid is low.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear all pending flags, all countdowns, mdu_busy and the MDU tag.
REQ-031 SHALL force busy_vec to 0 and stall to 0 during reset.
REQ-032 SHALL discard an in-flight MULDIV when reset is asserted mid-operation; no wb_mdu_valid is expected afterwards.

Structure
REQ-033 SHALL place the lat_class enum (ALU, LOAD, MULDIV) and the REG_ADDR_W=5 constant in the shared core package.
REQ-034 SHALL instantiate sub-module sb_entry (pending flag plus countdown) once per register through a generate loop.

Verification
REQ-035 SHALL cover load-use: LOAD x5, then ADD x6,x5,x1 -> stall high exactly 1 cycle, then issue.
REQ-036 SHALL cover MULDIV dependency: MUL x7 issued, dependent SUB x8,x7,x2 -> stall until 1 cycle after wb_mdu_valid with rd=7.
REQ-037 SHALL cover structural stall: second DIV x9 issued while mdu_busy=1 -> stall; issue in the cycle after writeback clears mdu_busy.
REQ-038 SHALL cover x0: LOAD x0 then ADD x1,x0,x0 -> busy_vec=0 and no stall.
REQ-039 SHALL cover WAW with flush: MUL x4 pending, LOAD x4 with flush=1 -> no entry change; the same LOAD without flush stalls until x4 clears.
REQ-040 SHALL cover mid-operation reset: rst_n pulsed low with MUL x3 outstanding -> busy_vec=0, mdu_busy=0 and stall=0 immediately.
